// File: rtl/counter_request_cells.sv
// counter_request_cells
// Per-channel plus/minus request cells fed by rising edges of the interface
// pulse lines. A fixed-priority chain (channel 0 highest) picks one pending
// cell and presents it to the counter sequencer. The grant is held until ACK.
// Optional feature macro: COUNTER_CANCEL_EN -- when defined, an opposite
// direction event cancels an ungranted pending count instead of queueing it.
module counter_request_cells #(
    parameter int NCH = 8,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] PLUS,
    input  logic [NCH-1:0] MINUS,
    input  logic           ACK,
    input  logic           OVCLR,
    output logic           REQ,
    output logic [CW-1:0]  CHAN,
    output logic           DIRP,
    output logic           DIRM,
    output logic [NCH-1:0] PEND,
    output logic [NCH-1:0] OVRUN
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Index of the lowest set bit; zero when nothing is set.
    function automatic logic [CW-1:0] first_set(input logic [NCH-1:0] vec);
        logic [CW-1:0] idx;
        idx = {CW{1'b0}};
        for (int i = NCH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Edge-detect history
    logic [NCH-1:0] plus_prev_r;
    logic [NCH-1:0] minus_prev_r;

    // Request cells and flags
    logic [NCH-1:0] p_r;
    logic [NCH-1:0] m_r;
    logic [NCH-1:0] pend_r;
    logic [NCH-1:0] ovrun_r;

    // Grant state
    logic [0:0]     state_r;
    logic           req_r;
    logic [CW-1:0]  chan_r;
    logic           dirp_r;
    logic           dirm_r;

    // Combinational helpers
    logic [NCH-1:0] plus_evt_s;
    logic [NCH-1:0] minus_evt_s;
    logic [NCH-1:0] plus_only_s;
    logic [NCH-1:0] minus_only_s;
    logic           ack_s;
    logic [NCH-1:0] pend_any_s;
    logic           sel_vld_s;
    logic [CW-1:0]  sel_idx_s;
    logic           sel_plus_s;
    logic           taking_s;
    logic [NCH-1:0] gp_s;
    logic [NCH-1:0] gm_s;
    logic [NCH-1:0] clr_p_s;
    logic [NCH-1:0] clr_m_s;
    logic [NCH-1:0] p_nxt_s;
    logic [NCH-1:0] m_nxt_s;
    logic [NCH-1:0] ov_set_s;
    logic [NCH-1:0] ov_nxt_s;

    // Count events, acknowledge qualification and priority selection.
    always_comb begin
        plus_evt_s   = PLUS & ~plus_prev_r;
        minus_evt_s  = MINUS & ~minus_prev_r;
        // Opposing events in the same cycle cancel each other outright.
        plus_only_s  = plus_evt_s & ~minus_evt_s;
        minus_only_s = minus_evt_s & ~plus_evt_s;
        // An ACK without a presented grant has nothing to acknowledge.
        ack_s        = ACK & (state_r == ST_GRANT);
        pend_any_s   = p_r | m_r;
        sel_vld_s    = |pend_any_s;
        sel_idx_s    = first_set(pend_any_s);
        // Plus is served before minus when both are pending on a channel.
        sel_plus_s   = p_r[sel_idx_s];
        taking_s     = (state_r == ST_IDLE) & sel_vld_s;
    end

    // Which cell bits are granted (held or being latched this cycle); these are
    // protected from cancellation and are the ones an ACK clears.
    always_comb begin
        gp_s = {NCH{1'b0}};
        gm_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            gp_s[i] = ((state_r == ST_GRANT) & (chan_r == CW'(i)) & dirp_r) |
                      (taking_s & (sel_idx_s == CW'(i)) & sel_plus_s);
            gm_s[i] = ((state_r == ST_GRANT) & (chan_r == CW'(i)) & dirm_r) |
                      (taking_s & (sel_idx_s == CW'(i)) & ~sel_plus_s);
        end
        clr_p_s = {NCH{ack_s}} & gp_s;
        clr_m_s = {NCH{ack_s}} & gm_s;
    end

    // Next pending bits and overrun detection; a new event beats a same-cycle clear.
    always_comb begin
        p_nxt_s  = p_r;
        m_nxt_s  = m_r;
        ov_set_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (clr_p_s[i]) begin
                p_nxt_s[i] = 1'b0;
            end else begin
                p_nxt_s[i] = p_r[i];
            end
            if (clr_m_s[i]) begin
                m_nxt_s[i] = 1'b0;
            end else begin
                m_nxt_s[i] = m_r[i];
            end
`ifdef COUNTER_CANCEL_EN
            if (plus_only_s[i] && m_r[i] && !gm_s[i]) begin
                // Net-zero pair: drop the waiting minus, never queue the plus.
                m_nxt_s[i] = 1'b0;
            end else if (plus_only_s[i]) begin
                ov_set_s[i] = p_r[i] & ~clr_p_s[i];
                p_nxt_s[i]  = 1'b1;
            end else if (minus_only_s[i] && p_r[i] && !gp_s[i]) begin
                p_nxt_s[i] = 1'b0;
            end else if (minus_only_s[i]) begin
                ov_set_s[i] = m_r[i] & ~clr_m_s[i];
                m_nxt_s[i]  = 1'b1;
            end else begin
                ov_set_s[i] = 1'b0;
            end
`else
            if (plus_only_s[i]) begin
                ov_set_s[i] = p_r[i] & ~clr_p_s[i];
                p_nxt_s[i]  = 1'b1;
            end else begin
                p_nxt_s[i] = p_nxt_s[i];
            end
            if (minus_only_s[i]) begin
                ov_set_s[i] = ov_set_s[i] | (m_r[i] & ~clr_m_s[i]);
                m_nxt_s[i]  = 1'b1;
            end else begin
                m_nxt_s[i] = m_nxt_s[i];
            end
`endif
        end
        // A fresh overrun outlasts a simultaneous clear.
        ov_nxt_s = ov_set_s | (ovrun_r & ~{NCH{OVCLR}});
    end

    // Edge history, request cells, pending monitor and overrun flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            plus_prev_r  <= {NCH{1'b0}};
            minus_prev_r <= {NCH{1'b0}};
            p_r          <= {NCH{1'b0}};
            m_r          <= {NCH{1'b0}};
            pend_r       <= {NCH{1'b0}};
            ovrun_r      <= {NCH{1'b0}};
        end else begin
            plus_prev_r  <= PLUS;
            minus_prev_r <= MINUS;
            p_r          <= p_nxt_s;
            m_r          <= m_nxt_s;
            pend_r       <= p_nxt_s | m_nxt_s;
            ovrun_r      <= ov_nxt_s;
        end
    end

    // Grant FSM: latch the highest-priority cell and hold it until acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            chan_r  <= {CW{1'b0}};
            dirp_r  <= 1'b0;
            dirm_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sel_vld_s) begin
                        state_r <= ST_GRANT;
                        req_r   <= 1'b1;
                        chan_r  <= sel_idx_s;
                        dirp_r  <= sel_plus_s;
                        dirm_r  <= ~sel_plus_s;
                    end else begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                        chan_r  <= chan_r;
                        dirp_r  <= 1'b0;
                        dirm_r  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (ack_s) begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                        chan_r  <= chan_r;
                        dirp_r  <= 1'b0;
                        dirm_r  <= 1'b0;
                    end else begin
                        state_r <= ST_GRANT;
                        req_r   <= 1'b1;
                        chan_r  <= chan_r;
                        dirp_r  <= dirp_r;
                        dirm_r  <= dirm_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                    chan_r  <= {CW{1'b0}};
                    dirp_r  <= 1'b0;
                    dirm_r  <= 1'b0;
                end
            endcase
        end
    end

    assign REQ   = req_r;
    assign CHAN  = chan_r;
    assign DIRP  = dirp_r;
    assign DIRM  = dirm_r;
    assign PEND  = pend_r;
    assign OVRUN = ovrun_r;

endmodule

// File: tb/tb_counter_request_cells.sv
// Self-checking bench for counter_request_cells: directed scenarios plus
// randomized pulses, compared against a behavioural request-cell model.
module tb_counter_request_cells;

    localparam int NCH = 8;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] PLUS;
    logic [NCH-1:0] MINUS;
    logic           ACK;
    logic           OVCLR;
    logic           REQ;
    logic [2:0]     CHAN;
    logic           DIRP;
    logic           DIRM;
    logic [NCH-1:0] PEND;
    logic [NCH-1:0] OVRUN;

    int n_checks;
    int n_pass;

    // Reference state: what is waiting, what is being served, what overflowed.
    logic [NCH-1:0] mp;
    logic [NCH-1:0] mm;
    logic [NCH-1:0] m_ov;
    logic [NCH-1:0] prevp;
    logic [NCH-1:0] prevm;
    logic           m_busy;
    int             m_chan;
    logic           m_dirp;

    counter_request_cells #(.NCH(NCH)) dut (
        .clk   (clk),
        .rst   (rst),
        .PLUS  (PLUS),
        .MINUS (MINUS),
        .ACK   (ACK),
        .OVCLR (OVCLR),
        .REQ   (REQ),
        .CHAN  (CHAN),
        .DIRP  (DIRP),
        .DIRM  (DIRM),
        .PEND  (PEND),
        .OVRUN (OVRUN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        mp     = '0;
        mm     = '0;
        m_ov   = '0;
        prevp  = '0;
        prevm  = '0;
        m_busy = 1'b0;
        m_chan = 0;
        m_dirp = 1'b0;
    endtask

    // One clock of the request-cell rules, applied to the inputs of that cycle.
    task automatic model_step(input logic [NCH-1:0] p, input logic [NCH-1:0] m,
                              input logic a, input logic oc);
        logic [NCH-1:0] np;
        logic [NCH-1:0] nm;
        logic [NCH-1:0] nov;
        int   pick;
        logic pick_plus;
        logic acked;
        acked = a && m_busy;
        pick = -1;
        pick_plus = 1'b0;
        if (!m_busy) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (mp[i] || mm[i]) pick = i;
            end
        end
        if (pick >= 0) pick_plus = mp[pick];
        np  = mp;
        nm  = mm;
        nov = oc ? '0 : m_ov;
        if (acked) begin
            if (m_dirp) np[m_chan] = 1'b0;
            else        nm[m_chan] = 1'b0;
        end
        for (int i = 0; i < NCH; i++) begin
            logic ep;
            logic em;
            logic locked_p;
            logic locked_m;
            ep = p[i] && !prevp[i];
            em = m[i] && !prevm[i];
            locked_p = (m_busy && m_chan == i && m_dirp) || (pick == i && pick_plus);
            locked_m = (m_busy && m_chan == i && !m_dirp) || (pick == i && !pick_plus);
            if (ep && !em) begin
`ifdef COUNTER_CANCEL_EN
                if (mm[i] && !locked_m) begin
                    nm[i] = 1'b0;
                end else begin
                    if (np[i]) nov[i] = 1'b1;
                    np[i] = 1'b1;
                end
`else
                if (np[i]) nov[i] = 1'b1;
                np[i] = 1'b1;
`endif
            end
            if (em && !ep) begin
`ifdef COUNTER_CANCEL_EN
                if (mp[i] && !locked_p) begin
                    np[i] = 1'b0;
                end else begin
                    if (nm[i]) nov[i] = 1'b1;
                    nm[i] = 1'b1;
                end
`else
                if (nm[i]) nov[i] = 1'b1;
                nm[i] = 1'b1;
`endif
            end
        end
        if (m_busy) begin
            if (acked) m_busy = 1'b0;
        end else if (pick >= 0) begin
            m_busy = 1'b1;
            m_chan = pick;
            m_dirp = pick_plus;
        end
        mp    = np;
        mm    = nm;
        m_ov  = nov;
        prevp = p;
        prevm = m;
    endtask

    task automatic compare_all();
        check("REQ", 32'(REQ), 32'(m_busy));
        check("PEND", 32'(PEND), 32'(mp | mm));
        check("OVRUN", 32'(OVRUN), 32'(m_ov));
        if (m_busy) begin
            check("CHAN", 32'(CHAN), 32'(m_chan));
            check("DIRP", 32'(DIRP), 32'(m_dirp));
            check("DIRM", 32'(DIRM), 32'(!m_dirp));
        end
    endtask

    // Apply one cycle of inputs, advance past the edge, then compare.
    task automatic cyc(input logic [NCH-1:0] p, input logic [NCH-1:0] m,
                       input logic a, input logic oc);
        PLUS  = p;
        MINUS = m;
        ACK   = a;
        OVCLR = oc;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(p, m, a, oc);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int   grants;
        logic req_q;
        n_checks = 0;
        n_pass   = 0;
        rst   = 1'b1;
        PLUS  = '0;
        MINUS = '0;
        ACK   = 1'b0;
        OVCLR = 1'b0;
        model_reset();
        idle(2);
        check("reset_req", 32'(REQ), 32'd0);
        check("reset_ovrun", 32'(OVRUN), 32'd0);
        rst = 1'b0;
        idle(2);

        // Reset asserted while a grant is presented.
        cyc(8'h20, '0, 1'b0, 1'b0);
        idle(1);
        check("pre_rst_req", 32'(REQ), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_req", 32'(REQ), 32'd0);
        check("async_rst_pend", 32'(PEND), 32'd0);
        model_reset();
        idle(2);
        rst = 1'b0;
        idle(1);

        // Single plus on channel 3 and its latency.
        cyc(8'h08, '0, 1'b0, 1'b0);
        check("t1_pend3", 32'(PEND[3]), 32'd1);
        check("t1_req_n1", 32'(REQ), 32'd0);
        idle(1);
        check("t1_req", 32'(REQ), 32'd1);
        check("t1_chan", 32'(CHAN), 32'd3);
        check("t1_dirp", 32'(DIRP), 32'd1);
        idle(2);
        cyc('0, '0, 1'b1, 1'b0);
        check("t1_req_off", 32'(REQ), 32'd0);
        check("t1_pend_off", 32'(PEND), 32'd0);
        idle(2);

        // Priority without preemption.
        cyc('0, 8'h20, 1'b0, 1'b0);
        idle(2);
        cyc(8'h02, '0, 1'b0, 1'b0);
        check("t2_hold_chan", 32'(CHAN), 32'd5);
        check("t2_dirm", 32'(DIRM), 32'd1);
        idle(2);
        check("t2_still5", 32'(CHAN), 32'd5);
        cyc('0, '0, 1'b1, 1'b0);
        check("t2_gap", 32'(REQ), 32'd0);
        idle(1);
        check("t2_next_req", 32'(REQ), 32'd1);
        check("t2_next_chan", 32'(CHAN), 32'd1);
        check("t2_next_dirp", 32'(DIRP), 32'd1);
        cyc('0, '0, 1'b1, 1'b0);
        idle(2);

        // Overrun and its clear.
        cyc(8'h04, '0, 1'b0, 1'b0);
        idle(1);
        cyc(8'h04, '0, 1'b0, 1'b0);
        check("t3_ovrun", 32'(OVRUN[2]), 32'd1);
        cyc('0, '0, 1'b1, 1'b0);
        idle(2);
        check("t3_one_grant", 32'(REQ), 32'd0);
        cyc('0, '0, 1'b0, 1'b1);
        check("t3_ovclr", 32'(OVRUN[2]), 32'd0);
        idle(1);

        // New event on the granted cell in the ACK cycle.
        cyc(8'h10, '0, 1'b0, 1'b0);
        idle(1);
        cyc(8'h10, '0, 1'b1, 1'b0);
        check("t4_pend4", 32'(PEND[4]), 32'd1);
        check("t4_no_ov", 32'(OVRUN[4]), 32'd0);
        idle(1);
        check("t4_regrant", 32'(REQ), 32'd1);
        check("t4_chan", 32'(CHAN), 32'd4);
        cyc('0, '0, 1'b1, 1'b0);
        idle(2);

        // Opposing events on channel 6.
        cyc(8'h40, 8'h40, 1'b0, 1'b0);
        check("t5_simul", 32'(PEND[6]), 32'd0);
        cyc(8'h01, '0, 1'b0, 1'b0);
        idle(1);
        cyc(8'h40, '0, 1'b0, 1'b0);
        idle(1);
        cyc('0, 8'h40, 1'b0, 1'b0);
`ifdef COUNTER_CANCEL_EN
        check("t5_cancel", 32'(PEND[6]), 32'd0);
        idle(1);
        cyc('0, '0, 1'b1, 1'b0);
        idle(1);
        check("t5_no_grant", 32'(REQ), 32'd0);
`else
        check("t5_both", 32'(PEND[6]), 32'd1);
        idle(1);
        cyc('0, '0, 1'b1, 1'b0);
        idle(1);
        check("t5_plus_chan", 32'(CHAN), 32'd6);
        check("t5_plus_dir", 32'(DIRP), 32'd1);
        cyc('0, '0, 1'b1, 1'b0);
        idle(1);
        check("t5_minus_chan", 32'(CHAN), 32'd6);
        check("t5_minus_dir", 32'(DIRM), 32'd1);
        cyc('0, '0, 1'b1, 1'b0);
`endif
        idle(2);

        // PLUS[7] held high through reset release.
        rst = 1'b1;
        cyc(8'h80, '0, 1'b0, 1'b0);
        cyc(8'h80, '0, 1'b0, 1'b0);
        rst = 1'b0;
        grants = 0;
        req_q  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(8'h80, '0, m_busy, 1'b0);
            if (REQ && !req_q && CHAN == 3'd7) grants++;
            req_q = REQ;
        end
        check("t6_grants", 32'(grants), 32'd1);
        idle(2);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            logic [NCH-1:0] rp;
            logic [NCH-1:0] rm;
            logic           ra;
            rp = NCH'($urandom & $urandom & $urandom);
            rm = NCH'($urandom & $urandom & $urandom);
            ra = m_busy ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            cyc(rp, rm, ra, $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_request_cells.md
# counter_request_cells

Latches the plus/minus increment pulses coming from the A24 interface stage and neighbouring interface modules (CDU, PIPA, BMAG, shaft/trunnion lines) into per-channel request cells. A fixed-priority chain selects one pending cell and presents it to the counter-sequence logic downstream. The grant is held until that logic acknowledges the service. The block sits between the pulse-producing interface modules and the counter priority/sequence generator that performs PINC/MINC cycles.

## Interface
- NCH, 8, number of counter channels; channel 0 has highest priority.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- PLUS  in  NCH  per-channel plus pulse; level, any length ≥1 cycle; a rising edge is one count.
- MINUS  in  NCH  per-channel minus pulse; same rules as PLUS.
- ACK  in  1  service acknowledge from counter sequencer; one-cycle pulse, valid only while REQ=1.
- OVCLR  in  1  clears all overrun flags.
- REQ  out  1  a granted request is being presented.
- CHAN  out  $clog2(NCH)  granted channel index.
- DIRP  out  1  granted request is plus; DIRM is its complement while REQ=1.
- DIRM  out  1  granted request is minus.
- PEND  out  NCH  per-channel "any direction pending" (debug/monitor).
- OVRUN  out  NCH  sticky per-channel overrun flag.

## Operation
- Edge detect: registered copy of PLUS/MINUS; a count event is input=1 and previous=0. The previous-value registers reset to 0. A line held high through reset therefore produces an event on the first cycle after release.
- Each channel has two pending bits, P[i] and M[i].
- A plus event sets P[i]. A minus event sets M[i].
- A same-direction event while that bit is already set (and not being cleared this cycle) sets OVRUN[i]. The count is lost.
- Simultaneous plus and minus events on one channel in the same cycle: both discarded, no overrun.
- Grant FSM, two states:
  - IDLE: REQ=0. If any cell is pending, select the lowest index i, latch CHAN=i and direction (plus if P[i], else minus), and go to GRANT.
  - GRANT: REQ=1 and CHAN/DIRP/DIRM frozen. Higher-priority arrivals do not preempt. On ACK, clear the granted bit and go to IDLE.
- ACK and a new same-direction event on the granted cell in the same cycle: the bit remains set (set wins) and no overrun is flagged.
- ACK while REQ=0 is ignored.
- OVCLR clears all OVRUN bits. A new overrun in the same cycle as OVCLR wins and the bit stays set.
- PEND[i] = P[i] | M[i].

## Timing
- Reset values: REQ=0, CHAN=0, DIRP=0, DIRM=0, PEND=0, OVRUN=0, all pending and edge registers 0, FSM=IDLE.
- Pulse to pending: the rising edge at input on cycle n sets the bit at the end of cycle n, so PEND is visible in cycle n+1.
- Pending to REQ: REQ rises one cycle after PEND, so REQ is visible in cycle n+2 from the input edge.
- ACK in cycle k: REQ=0 in k+1. The next grant, if any, appears in k+2. Minimum gap is one idle cycle.
- Reset asserted mid-GRANT drops REQ and all pending state immediately; in-flight counts are discarded.

## Configuration
- COUNTER_CANCEL_EN defined:
  - A plus event while M[i] is set, with M[i] not granted, clears M[i] instead of setting P[i].
  - A minus event while P[i] is set, with P[i] not granted, clears P[i] instead of setting M[i].
  - Net-zero pairs never reach the sequencer.
  - Cancellation against a granted bit is not allowed; the opposite bit is set normally.
- Undefined: P and M are independent. When both are set, plus is granted first and minus on the following grant.

## Test plan
- Reset and single plus: assert rst mid-run, then release; pulse PLUS[3] for one cycle at n -> PEND[3]=1 at n+1; REQ=1, CHAN=3, DIRP=1 at n+2; ACK at n+4 -> REQ=0 at n+5, PEND=0.
- Priority and no preemption: MINUS[5] at n, PLUS[1] at n+3 while channel 5 is granted -> CHAN stays 5 until ACK; next grant is CHAN=1 with DIRP=1, two cycles after ACK.
- Overrun: PLUS[2] twice without ACK -> OVRUN[2]=1 and one grant only; pulse OVCLR -> OVRUN[2]=0.
- Set beats clear: PLUS[4] edge in the same cycle as ACK of granted plus on 4 -> P[4] remains set, OVRUN[4]=0, re-granted two cycles later.
- Simultaneous and opposing events: PLUS[6] and MINUS[6] in the same cycle -> no pending. PLUS[6] then MINUS[6] with channel 0 held busy -> with COUNTER_CANCEL_EN, PEND[6]=0 and no grant; without it, plus is granted then minus.
- Held level across reset: PLUS[7] held high through reset release -> exactly one plus grant on channel 7, no further events until the line drops and rises again.
